// File: rtl/hyperbus_arbiter_pkg.sv
// Shared constants for the Hyperbus arbiter: one-hot FSM state codes,
// transfer direction encoding and the beat counter width.
package hyperbus_arbiter_pkg;

    localparam logic [3:0] ST_IDLE  = 4'b0001;
    localparam logic [3:0] ST_ISSUE = 4'b0010;
    localparam logic [3:0] ST_DATA  = 4'b0100;
    localparam logic [3:0] ST_DONE  = 4'b1000;

    localparam logic DIR_READ  = 1'b1;
    localparam logic DIR_WRITE = 1'b0;

    // BEATS is limited to 255, so eight bits always hold the load value.
    localparam int CNT_W = 8;

endpackage

// File: rtl/hyperbus_arbiter_if.sv
// Bundles the requester-side and controller-side signals of the arbiter.
// slave = arbiter view, master = environment (bridges + controller) view.
interface hyperbus_arbiter_if
    import hyperbus_arbiter_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 16
);

    // Handshake: a beat moves in every DATA cycle where the controller raises
    // hbus_valid (read) or hbus_ready (write); the arbiter mirrors it onto the
    // granted requester's req_valid/req_ready in that same cycle, no backpressure.
    logic [NREQ-1:0]            req_rrq;
    logic [NREQ-1:0]            req_wrq;
    logic [NREQ*ADDR_WIDTH-1:0] req_adr;
    logic [NREQ*DATA_WIDTH-1:0] req_dat_i;
    logic [NREQ-1:0]            req_gnt;
    logic [NREQ-1:0]            req_ready;
    logic [NREQ-1:0]            req_valid;
    logic [DATA_WIDTH-1:0]      req_dat_o;
    logic [NREQ-1:0]            req_done;
    logic [NREQ-1:0]            req_err;
    logic [ADDR_WIDTH-1:0]      hbus_adr_o;
    logic [DATA_WIDTH-1:0]      hbus_dat_o;
    logic [DATA_WIDTH-1:0]      hbus_dat_i;
    logic                       hbus_rrq;
    logic                       hbus_wrq;
    logic                       hbus_ready;
    logic                       hbus_valid;
    logic                       hbus_busy;

    modport slave (
        input  req_rrq, req_wrq, req_adr, req_dat_i,
        input  hbus_dat_i, hbus_ready, hbus_valid, hbus_busy,
        output req_gnt, req_ready, req_valid, req_dat_o, req_done, req_err,
        output hbus_adr_o, hbus_dat_o, hbus_rrq, hbus_wrq
    );

    modport master (
        output req_rrq, req_wrq, req_adr, req_dat_i,
        output hbus_dat_i, hbus_ready, hbus_valid, hbus_busy,
        input  req_gnt, req_ready, req_valid, req_dat_o, req_done, req_err,
        input  hbus_adr_o, hbus_dat_o, hbus_rrq, hbus_wrq
    );

endinterface

// File: rtl/hyperbus_arbiter_picker.sv
// Combinational round-robin picker: first pending requester after 'last',
// wrapping modulo NREQ; returns one-hot grant, its index and an any flag.
module hyperbus_rr_picker
    import hyperbus_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDXW = 1
) (
    input  logic [NREQ-1:0] pending_i,
    input  logic [IDXW-1:0] last_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDXW-1:0] idx_o,
    output logic            any_o
);

    always_comb begin
        int j;
        j     = 0;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        // k runs 1..NREQ so the previous winner is considered last.
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(last_i) + k) % NREQ;
            if (!any_o && pending_i[j]) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IDXW'(j);
            end
        end
    end

endmodule

// File: rtl/hyperbus_arbiter.sv
// Round-robin arbiter sharing one Hyperbus controller between NREQ requesters.
// Optional watchdog abort in DATA is enabled by defining HBUS_ARB_TIMEOUT_EN.
module hyperbus_arbiter
    import hyperbus_arbiter_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 16,
    parameter int BEATS      = 2,
    parameter int TIMEOUT    = 1024
) (
    input  logic              hbus_clk,
    input  logic              hbus_rst,
    hyperbus_arbiter_if.slave bus,
    output logic [3:0]        dbg_state_o
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [3:0]            state_q, state_d;
    logic [IDXW-1:0]       idx_q, idx_d;
    logic [IDXW-1:0]       last_q, last_d;
    logic [NREQ-1:0]       gnt_q, gnt_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic                  dir_q, dir_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [NREQ-1:0] pick_gnt;
    logic [IDXW-1:0] pick_idx;
    logic            pick_any;
    logic            in_issue, in_data, in_done;
    logic            beat, wd_hit, err_q, release_now;

    hyperbus_rr_picker #(.NREQ(NREQ), .IDXW(IDXW)) u_picker (
        .pending_i (bus.req_rrq | bus.req_wrq),
        .last_i    (last_q),
        .gnt_o     (pick_gnt),
        .idx_o     (pick_idx),
        .any_o     (pick_any)
    );

    assign in_issue    = (state_q == ST_ISSUE);
    assign in_data     = (state_q == ST_DATA);
    assign in_done     = (state_q == ST_DONE);
    assign beat        = in_data && ((dir_q == DIR_READ) ? bus.hbus_valid : bus.hbus_ready);
    assign release_now = in_done && !bus.hbus_busy;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        adr_d   = adr_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    idx_d   = pick_idx;
                    gnt_d   = pick_gnt;
                    adr_d   = bus.req_adr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                    dir_d   = bus.req_rrq[pick_idx] ? DIR_READ : DIR_WRITE;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = CNT_W'(BEATS);
                state_d = ST_DATA;
            end
            ST_DATA: begin
                if (beat) cnt_d = cnt_q - CNT_W'(1);
                if ((beat && cnt_q == CNT_W'(1)) || wd_hit) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!bus.hbus_busy) begin
                    gnt_d   = '0;
                    last_d  = idx_q;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge hbus_clk or posedge hbus_rst) begin
        if (hbus_rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            last_q  <= IDXW'(NREQ - 1);
            gnt_q   <= '0;
            adr_q   <= '0;
            dir_q   <= DIR_WRITE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            adr_q   <= adr_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HBUS_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_q;

    // wd_q counts consecutive beat-less DATA cycles; the TIMEOUT-th one aborts.
    assign wd_hit = in_data && !beat && (wd_q == WD_W'(TIMEOUT - 1));

    always_ff @(posedge hbus_clk or posedge hbus_rst) begin
        if (hbus_rst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else if (in_issue) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else if (in_data) begin
            wd_q <= beat ? '0 : wd_q + WD_W'(1);
            if (wd_hit) err_q <= 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
    assign wd_hit         = 1'b0;
    assign err_q          = 1'b0;
`endif

    assign bus.req_gnt    = gnt_q;
    assign bus.req_valid  = (beat && dir_q == DIR_READ)  ? gnt_q : '0;
    assign bus.req_ready  = (beat && dir_q == DIR_WRITE) ? gnt_q : '0;
    assign bus.req_dat_o  = (in_data && dir_q == DIR_READ) ? bus.hbus_dat_i : '0;
    assign bus.req_done   = release_now ? gnt_q : '0;
    assign bus.req_err    = (release_now && err_q) ? gnt_q : '0;
    assign bus.hbus_adr_o = adr_q;
    assign bus.hbus_dat_o = (state_q != ST_IDLE) ?
                            bus.req_dat_i[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign bus.hbus_rrq   = in_issue && (dir_q == DIR_READ);
    assign bus.hbus_wrq   = in_issue && (dir_q == DIR_WRITE);
    assign dbg_state_o    = state_q;

endmodule
